// File: rtl/udm_mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter and its picker.
package udm_mem_arbiter_pkg;

   localparam int unsigned NUM_MASTERS = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_RESP = 2'd2
   } arb_state_e;

   typedef logic owner_t;

   localparam owner_t MASTER_CPU = 1'b0;
   localparam owner_t MASTER_DBG = 1'b1;

   // Encode a one-hot two-way grant as the owning master id.
   function automatic owner_t grant_owner(input logic [NUM_MASTERS-1:0] grant);
      return grant[MASTER_DBG] ? MASTER_DBG : MASTER_CPU;
   endfunction

endpackage

// File: rtl/udm_arb2_pick.sv
// Combinational two-way picker returning a one-hot grant.
// MEM_ARB_ROUND_ROBIN_EN: pointer breaks ties; undefined: debug master always wins ties.
module udm_arb2_pick
   import udm_mem_arbiter_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  owner_t                 ptr,
   output logic [NUM_MASTERS-1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      grant = req;
      if (&req) begin
         grant = (ptr == MASTER_DBG) ? 2'b10 : 2'b01;
      end
   end
`else
   // Fixed priority has no use for the pointer.
   logic unused_ptr;
   assign unused_ptr = ptr;

   always_comb begin
      grant = req;
      if (req[MASTER_DBG]) begin
         grant = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/udm_mem_arbiter.sv
// Shares one req/ack memory port between the core data bus (m0) and the UART debug bus (m1).
// Tie-break policy lives in udm_arb2_pick and is selected by MEM_ARB_ROUND_ROBIN_EN.
module udm_mem_arbiter
   import udm_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
)(
   input  logic                    clk_i,
   input  logic                    arstn_i,

   input  logic                    m0_req_i,
   output logic                    m0_ack_o,
   input  logic                    m0_we_i,
   input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
   input  logic [DATA_WIDTH/8-1:0] m0_be_i,
   input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
   output logic                    m0_resp_o,
   output logic [DATA_WIDTH-1:0]   m0_rdata_o,

   input  logic                    m1_req_i,
   output logic                    m1_ack_o,
   input  logic                    m1_we_i,
   input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
   input  logic [DATA_WIDTH/8-1:0] m1_be_i,
   input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
   output logic                    m1_resp_o,
   output logic [DATA_WIDTH-1:0]   m1_rdata_o,

   output logic                    s_req_o,
   input  logic                    s_ack_i,
   output logic                    s_we_o,
   output logic [ADDR_WIDTH-1:0]   s_addr_o,
   output logic [DATA_WIDTH/8-1:0] s_be_o,
   output logic [DATA_WIDTH-1:0]   s_wdata_o,
   input  logic                    s_resp_i,
   input  logic [DATA_WIDTH-1:0]   s_rdata_i
);

   arb_state_e             state_q;
   arb_state_e             state_d;
   owner_t                 owner_q;
   owner_t                 ptr_q;
   owner_t                 win;
   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] grant;
   logic                   accept;

   assign req = {m1_req_i, m0_req_i};

   udm_arb2_pick u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (grant)
   );

   assign accept = (state_q == IDLE) && (|req);
   assign win    = grant_owner(grant);

   // Acks and response strobes are combinational so a master sees them in the same cycle.
   assign m0_ack_o   = (state_q == IDLE) && grant[MASTER_CPU];
   assign m1_ack_o   = (state_q == IDLE) && grant[MASTER_DBG];
   assign m0_resp_o  = (state_q == WAIT_RESP) && s_resp_i && (owner_q == MASTER_CPU);
   assign m1_resp_o  = (state_q == WAIT_RESP) && s_resp_i && (owner_q == MASTER_DBG);
   assign m0_rdata_o = s_rdata_i;
   assign m1_rdata_o = s_rdata_i;

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (accept)   state_d = ISSUE;
         ISSUE:     if (s_ack_i)  state_d = s_we_o ? IDLE : WAIT_RESP;
         WAIT_RESP: if (s_resp_i) state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // State, owner, pointer and the registered slave request.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q   <= IDLE;
         owner_q   <= MASTER_CPU;
         ptr_q     <= MASTER_CPU;
         s_req_o   <= 1'b0;
         s_we_o    <= 1'b0;
         s_addr_o  <= '0;
         s_be_o    <= '0;
         s_wdata_o <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q   <= win;
            ptr_q     <= owner_t'(~win);
            s_req_o   <= 1'b1;
            s_we_o    <= (win == MASTER_DBG) ? m1_we_i    : m0_we_i;
            s_addr_o  <= (win == MASTER_DBG) ? m1_addr_i  : m0_addr_i;
            s_be_o    <= (win == MASTER_DBG) ? m1_be_i    : m0_be_i;
            s_wdata_o <= (win == MASTER_DBG) ? m1_wdata_i : m0_wdata_i;
         end else if ((state_q == ISSUE) && s_ack_i) begin
            s_req_o <= 1'b0;
         end
      end
   end

endmodule
